ld_timer_ctrl: RTL

- Controller for a cascade of 4-bit loadable down-counter slices with an active-low borrow chain (CI/CO).
- Upstream: drives the chain's D, SD (load select), SP (enable) and CI. Downstream: consumes the chain's final CO and Q.
- Turns the slice cascade into a programmable-period timer with a reload shadow register and a single-cycle tick output.

---
 rtl/ld_timer_pkg.sv | 20 ++
 rtl/ld_timer_fsm.sv | 75 +++++++
 rtl/ld_timer_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/ld_timer_pkg.sv
// rtl/ld_timer_pkg.sv - shared types and helpers for the ld_timer controller
//
// Purpose: FSM state encoding, slice width and the WIDTH helper used by
// ld_timer_fsm and ld_timer_ctrl.
// Ports: none (package).
package ld_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int SLICE_W = 4;

  function automatic int width_of(input int slices);
    return slices * SLICE_W;
  endfunction

endpackage

// File: rtl/ld_timer_fsm.sv
// rtl/ld_timer_fsm.sv - control FSM and chain strobe decode for ld_timer_ctrl
//
// Purpose: IDLE/LOAD/RUN state register, next-state logic and the
// combinational SD/SP/CI decode driven onto the counter chain.
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_start, i_stop    control pulses (stop has priority)
//   i_cnt_co_n         chain terminal borrow, active-low
//   o_state, o_next    current and next state
//   o_term             RUN cycle with terminal count
//   o_cnt_sd/sp/ci_n   chain load select, enable, borrow-in (active-low)
module ld_timer_fsm
  import ld_timer_pkg::*;
#(
  parameter bit AUTO_RELOAD = 1'b1
) (
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_start,
  input  logic   i_stop,
  input  logic   i_cnt_co_n,
  output state_t o_state,
  output state_t o_next,
  output logic   o_term,
  output logic   o_cnt_sd,
  output logic   o_cnt_sp,
  output logic   o_cnt_ci_n
);

  state_t r_state;
  state_t w_next;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    o_term     = 1'b0;
    o_cnt_sd   = 1'b0;
    o_cnt_sp   = 1'b0;
    o_cnt_ci_n = 1'b1;
    case (r_state)
      IDLE: begin
        if (i_start && !i_stop) w_next = LOAD;
      end
      LOAD: begin
        o_cnt_sp = 1'b1;
        o_cnt_sd = 1'b1;
        w_next   = i_stop ? IDLE : RUN;
      end
      RUN: begin
        o_cnt_sp   = 1'b1;
        o_cnt_ci_n = 1'b0;
        o_term     = !i_cnt_co_n;
        if (AUTO_RELOAD) begin
          o_cnt_sd = o_term;
        end else if (o_term) begin
          // One-shot: the chain sits at 0 and would wrap on this edge, so
          // the counting edge is suppressed to leave it holding 0.
          o_cnt_sp = 1'b0;
        end
        if (i_stop)                     w_next = IDLE;
        else if (i_start)               w_next = LOAD;
        else if (o_term && !AUTO_RELOAD) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign o_state = r_state;
  assign o_next  = w_next;

endmodule

// File: rtl/ld_timer_ctrl.sv
// rtl/ld_timer_ctrl.sv - programmable-period timer over a loadable down-counter chain
//
// Purpose: drives a cascade of 4-bit loadable down-counter slices as a
// periodic (or one-shot) timer with a period shadow register and a
// one-cycle tick. Optional capture feature under macro LD_TIMER_CAPTURE_EN.
// Ports:
//   CK, RST            clock, synchronous active-high reset
//   start, stop        load-and-run / halt pulses (stop wins)
//   period_we, period  period shadow write (tick interval = period+1)
//   cnt_q, cnt_co_n    chain Q and terminal borrow (active-low)
//   cnt_d, cnt_sd      chain load data and load select
//   cnt_sp, cnt_ci_n   chain enable and borrow-in (active-low)
//   tick, busy         terminal-count pulse, LOAD/RUN indicator
//   capture, cap_q, cap_vld  (LD_TIMER_CAPTURE_EN only) elapsed-count capture
module ld_timer_ctrl
  import ld_timer_pkg::*;
#(
  parameter int  SLICES      = 4,
  parameter bit  AUTO_RELOAD = 1'b1,
  localparam int WIDTH       = width_of(SLICES)
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             start,
  input  logic             stop,
  input  logic             period_we,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] cnt_q,
  input  logic             cnt_co_n,
  output logic [WIDTH-1:0] cnt_d,
  output logic             cnt_sd,
  output logic             cnt_sp,
  output logic             cnt_ci_n,
  output logic             tick,
  output logic             busy
`ifdef LD_TIMER_CAPTURE_EN
  ,
  input  logic             capture,
  output logic [WIDTH-1:0] cap_q,
  output logic             cap_vld
`endif
);

  state_t           w_state;
  state_t           w_next;
  logic             w_term;
  logic             w_enter_load;
  logic [WIDTH-1:0] r_period_shadow;
  logic [WIDTH-1:0] r_period_active;
  logic             r_tick;

  ld_timer_fsm #(
    .AUTO_RELOAD (AUTO_RELOAD)
  ) u_fsm (
    .i_clk      (CK),
    .i_rst      (RST),
    .i_start    (start),
    .i_stop     (stop),
    .i_cnt_co_n (cnt_co_n),
    .o_state    (w_state),
    .o_next     (w_next),
    .o_term     (w_term),
    .o_cnt_sd   (cnt_sd),
    .o_cnt_sp   (cnt_sp),
    .o_cnt_ci_n (cnt_ci_n)
  );

  assign w_enter_load = (w_next == LOAD) && (w_state != LOAD);

  always_ff @(posedge CK) begin
    if (RST) begin
      r_period_shadow <= '0;
      r_period_active <= '0;
      r_tick          <= 1'b0;
    end else begin
      if (period_we) r_period_shadow <= period;
      if (w_enter_load || w_term) r_period_active <= r_period_shadow;
      // A stop in the terminal cycle aborts the timer, so no tick follows.
      r_tick <= w_term && !stop;
    end
  end

  // On a reload edge the chain takes the value period_active is about to
  // hold, so a mid-period shadow write governs the very next period and
  // period_active always describes the period the chain is counting.
  assign cnt_d = w_term ? r_period_shadow : r_period_active;
  assign tick  = r_tick;
  assign busy  = (w_state != IDLE);

`ifdef LD_TIMER_CAPTURE_EN
  logic [WIDTH-1:0] r_cap_q;
  logic             r_cap_vld;

  always_ff @(posedge CK) begin
    if (RST) begin
      r_cap_q   <= '0;
      r_cap_vld <= 1'b0;
    end else begin
      r_cap_vld <= capture && (w_state == RUN);
      if (capture && (w_state == RUN)) r_cap_q <= r_period_active - cnt_q;
    end
  end

  assign cap_q   = r_cap_q;
  assign cap_vld = r_cap_vld;
`endif

endmodule
